// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default field widths,
// the result record and a small wrap-around helper.
package cdb_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_ENTRY_W = 2;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]   tag;
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_ENTRY_W-1:0] entry;
    } cdb_result_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small power-of-two result queue; one per functional unit. Push and pop
// must already be qualified by the caller (not full / not empty).
module result_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage is data only; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU result queues drained onto NUM_CDB broadcast slots each cycle with
// round-robin fairness; full queues backpressure their producers.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 3,
    parameter int NUM_CDB    = 2,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int ENTRY_W    = DEF_ENTRY_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           fu_valid,
    output logic [NUM_FU-1:0]           fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data,
    input  logic [NUM_FU*ENTRY_W-1:0]   fu_entry,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic [NUM_FU-1:0]           clear_valid,
    output logic [NUM_FU*ENTRY_W-1:0]   clear_entry
);

    localparam int RES_W = TAG_W + DATA_W + ENTRY_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
        logic [ENTRY_W-1:0] entry;
    } res_t;

    res_t               head  [NUM_FU];
    logic [CNT_W-1:0]   count [NUM_FU];
    logic [NUM_FU-1:0]  push_p0;
    logic [NUM_FU-1:0]  grant_p0;
    logic [NUM_CDB-1:0] slot_vld_p0;
    res_t               slot_res_p0 [NUM_CDB];
    logic [PTR_W-1:0]   last_fu_p0;
    logic [PTR_W-1:0]   rr_ptr;
    int                 n_grant;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
        assign fu_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
        assign push_p0[i]  = fu_valid[i] & fu_ready[i] & ~flush;

        result_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push_p0[i]),
            .pop   (grant_p0[i]),
            .din   ({fu_tag[i*TAG_W +: TAG_W], fu_data[i*DATA_W +: DATA_W],
                     fu_entry[i*ENTRY_W +: ENTRY_W]}),
            .head  (head[i]),
            .count (count[i])
        );
    end

    // Stage p0: round-robin scan from rr_ptr, filling slots in scan order.
    always_comb begin
        grant_p0    = '0;
        slot_vld_p0 = '0;
        slot_res_p0 = '{default: '0};
        last_fu_p0  = rr_ptr;
        n_grant     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (j == (int'(rr_ptr) + k) % NUM_FU && count[j] != '0 && n_grant < NUM_CDB) begin
                    grant_p0[j] = 1'b1;
                    last_fu_p0  = PTR_W'(j);
                    for (int s = 0; s < NUM_CDB; s++) begin
                        if (s == n_grant) begin
                            slot_vld_p0[s] = 1'b1;
                            slot_res_p0[s] = head[j];
                        end
                    end
                    n_grant = n_grant + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush && grant_p0 != '0) begin
            rr_ptr <= PTR_W'(wrap_inc(int'(last_fu_p0), NUM_FU));
        end
    end

    // Stage p1: registered broadcast and RS-entry release.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            clear_valid <= '0;
            clear_entry <= '0;
        end else begin
            for (int s = 0; s < NUM_CDB; s++) begin
                cdb_valid[s]                   <= slot_vld_p0[s];
                cdb_tag[s*TAG_W +: TAG_W]      <= slot_res_p0[s].tag;
                cdb_data[s*DATA_W +: DATA_W]   <= slot_res_p0[s].data;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                clear_valid[i]                   <= grant_p0[i];
                clear_entry[i*ENTRY_W +: ENTRY_W] <= grant_p0[i] ? head[i].entry : '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 2-slot/depth-4 instance for the main
// scenarios and a 1-slot/depth-2 instance for backpressure ordering.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        flush_a;
    logic [2:0]  fu_valid_a, fu_ready_a, clear_valid_a;
    logic [11:0] fu_tag_a;
    logic [47:0] fu_data_a;
    logic [5:0]  fu_entry_a, clear_entry_a;
    logic [1:0]  cdb_valid_a;
    logic [7:0]  cdb_tag_a;
    logic [31:0] cdb_data_a;

    logic        flush_b;
    logic [2:0]  fu_valid_b, fu_ready_b, clear_valid_b;
    logic [11:0] fu_tag_b;
    logic [47:0] fu_data_b;
    logic [5:0]  fu_entry_b, clear_entry_b;
    logic [0:0]  cdb_valid_b;
    logic [3:0]  cdb_tag_b;
    logic [15:0] cdb_data_b;

    cdb_arbiter #(.NUM_FU(3), .NUM_CDB(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a),
        .fu_valid(fu_valid_a), .fu_ready(fu_ready_a),
        .fu_tag(fu_tag_a), .fu_data(fu_data_a), .fu_entry(fu_entry_a),
        .cdb_valid(cdb_valid_a), .cdb_tag(cdb_tag_a), .cdb_data(cdb_data_a),
        .clear_valid(clear_valid_a), .clear_entry(clear_entry_a)
    );

    cdb_arbiter #(.NUM_FU(3), .NUM_CDB(1), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .fu_valid(fu_valid_b), .fu_ready(fu_ready_b),
        .fu_tag(fu_tag_b), .fu_data(fu_data_b), .fu_entry(fu_entry_b),
        .cdb_valid(cdb_valid_b), .cdb_tag(cdb_tag_b), .cdb_data(cdb_data_b),
        .clear_valid(clear_valid_b), .clear_entry(clear_entry_b)
    );

    int errors = 0;
    int checks = 0;
    int seq_a [3];
    int seq_b [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0;
        fu_valid_a = '0; fu_valid_b = '0;
        fu_tag_a = '0; fu_data_a = '0; fu_entry_a = '0;
        fu_tag_b = '0; fu_data_b = '0; fu_entry_b = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Producer model: FU i sends tag i, data i*0x1000+seq, entry seq[1:0].
    task automatic drive_seq_a();
        for (int i = 0; i < 3; i++) begin
            fu_tag_a[i*4 +: 4]    = 4'(i);
            fu_data_a[i*16 +: 16] = 16'(i * 4096 + seq_a[i]);
            fu_entry_a[i*2 +: 2]  = 2'(seq_a[i]);
        end
    endtask

    task automatic drive_seq_b();
        for (int i = 0; i < 3; i++) begin
            fu_tag_b[i*4 +: 4]    = 4'(i);
            fu_data_b[i*16 +: 16] = 16'(i * 4096 + seq_b[i]);
            fu_entry_b[i*2 +: 2]  = 2'(seq_b[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0;
        fu_valid_a = 3'b111; fu_tag_a = 12'hABC; fu_data_a = 48'h1111_2222_3333; fu_entry_a = 6'h3F;
        fu_valid_b = 3'b111; fu_tag_b = 12'hABC; fu_data_b = 48'h1111_2222_3333; fu_entry_b = 6'h3F;
        tick(); tick();
        checks++;
        if ({cdb_valid_a, cdb_tag_a, cdb_data_a} !== '0) begin
            errors++; $display("FAIL reset_cdb: got v=%b t=%h d=%h, want all 0", cdb_valid_a, cdb_tag_a, cdb_data_a);
        end
        checks++;
        if ({clear_valid_a, clear_entry_a} !== '0) begin
            errors++; $display("FAIL reset_clear: got v=%b e=%h, want 0", clear_valid_a, clear_entry_a);
        end
        rst = 1'b0;
        fu_valid_a = '0; fu_valid_b = '0;
        checks++;
        if (fu_ready_a !== 3'b111 || fu_ready_b !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got a=%b b=%b, want 111", fu_ready_a, fu_ready_b);
        end
        tick(); tick();
        checks++;
        if (cdb_valid_a !== 2'b00 || cdb_valid_b !== 1'b0 || clear_valid_a !== 3'b000) begin
            errors++; $display("FAIL reset_nothing_enqueued: got a=%b b=%b clr=%b, want 0", cdb_valid_a, cdb_valid_b, clear_valid_a);
        end
    endtask

    task automatic test_single();
        cdb_result_t r;
        apply_reset();
        r = '{tag: 4'd5, data: 16'h1234, entry: 2'd2};
        fu_valid_a = 3'b001;
        fu_tag_a[3:0] = r.tag; fu_data_a[15:0] = r.data; fu_entry_a[1:0] = r.entry;
        tick();
        fu_valid_a = 3'b000;
        checks++;
        if (cdb_valid_a !== 2'b00) begin
            errors++; $display("FAIL single_early: got cdb_valid=%b, want 00", cdb_valid_a);
        end
        tick();
        checks++;
        if (cdb_valid_a !== 2'b01 || cdb_tag_a[3:0] !== r.tag || cdb_data_a[15:0] !== r.data) begin
            errors++; $display("FAIL single_bcast: got v=%b t=%h d=%h, want v=01 t=5 d=1234", cdb_valid_a, cdb_tag_a[3:0], cdb_data_a[15:0]);
        end
        checks++;
        if (clear_valid_a !== 3'b001 || clear_entry_a !== 6'b000010) begin
            errors++; $display("FAIL single_clear: got v=%b e=%b, want v=001 e=000010", clear_valid_a, clear_entry_a);
        end
        tick();
        checks++;
        if (cdb_valid_a !== 2'b00 || clear_valid_a !== 3'b000) begin
            errors++; $display("FAIL single_one_cycle: got v=%b clr=%b, want 00/000", cdb_valid_a, clear_valid_a);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        fu_valid_a = 3'b111;
        fu_tag_a = {4'd3, 4'd2, 4'd1};
        fu_data_a = {16'hC003, 16'hB002, 16'hA001};
        fu_entry_a = {2'd3, 2'd2, 2'd1};
        tick();
        fu_valid_a = 3'b000;
        tick();
        checks++;
        if (cdb_valid_a !== 2'b11 || cdb_tag_a !== 8'h21 || cdb_data_a !== 32'hB002_A001) begin
            errors++; $display("FAIL contention_n: got v=%b t=%h d=%h, want v=11 t=21 d=b002a001", cdb_valid_a, cdb_tag_a, cdb_data_a);
        end
        checks++;
        if (clear_valid_a !== 3'b011 || clear_entry_a !== 6'b00_10_01) begin
            errors++; $display("FAIL contention_n_clear: got v=%b e=%b, want 011/001001", clear_valid_a, clear_entry_a);
        end
        tick();
        checks++;
        if (cdb_valid_a !== 2'b01 || cdb_tag_a !== 8'h03 || cdb_data_a !== 32'h0000_C003) begin
            errors++; $display("FAIL contention_n1: got v=%b t=%h d=%h, want v=01 t=03 d=0000c003", cdb_valid_a, cdb_tag_a, cdb_data_a);
        end
        checks++;
        if (clear_valid_a !== 3'b100 || clear_entry_a !== 6'b11_00_00) begin
            errors++; $display("FAIL contention_n1_clear: got v=%b e=%b, want 100/110000", clear_valid_a, clear_entry_a);
        end
        // With the pointer back at FU0 a fresh three-way push grants FU0 then FU1.
        fu_valid_a = 3'b111;
        tick();
        fu_valid_a = 3'b000;
        tick();
        checks++;
        if (cdb_valid_a !== 2'b11 || cdb_tag_a !== 8'h21) begin
            errors++; $display("FAIL contention_rr_ptr: got v=%b t=%h, want v=11 t=21", cdb_valid_a, cdb_tag_a);
        end
        tick();
    endtask

    task automatic test_fairness();
        int bcnt [3];
        int gcnt [3];
        int exp_fu [2];
        logic [2:0] acc;
        apply_reset();
        for (int i = 0; i < 3; i++) begin seq_a[i] = 0; bcnt[i] = 0; gcnt[i] = 0; end
        fu_valid_a = 3'b111;
        drive_seq_a();
        for (int c = -1; c < 30; c++) begin
            acc = fu_valid_a & fu_ready_a;
            tick();
            for (int i = 0; i < 3; i++) if (acc[i]) seq_a[i]++;
            drive_seq_a();
            if (c >= 0) begin
                case (c % 3)
                    0: begin exp_fu[0] = 0; exp_fu[1] = 1; end
                    1: begin exp_fu[0] = 2; exp_fu[1] = 0; end
                    default: begin exp_fu[0] = 1; exp_fu[1] = 2; end
                endcase
                checks++;
                if (cdb_valid_a !== 2'b11 || cdb_tag_a[3:0] !== 4'(exp_fu[0]) || cdb_tag_a[7:4] !== 4'(exp_fu[1])) begin
                    errors++; $display("FAIL fair_pair c=%0d: got v=%b t=%h, want v=11 slot0=%0d slot1=%0d", c, cdb_valid_a, cdb_tag_a, exp_fu[0], exp_fu[1]);
                end
                for (int s = 0; s < 2; s++) begin
                    checks++;
                    if (cdb_data_a[s*16 +: 16] !== 16'(exp_fu[s] * 4096 + bcnt[exp_fu[s]])) begin
                        errors++; $display("FAIL fair_order c=%0d slot%0d: got %h want %h", c, s, cdb_data_a[s*16 +: 16], 16'(exp_fu[s] * 4096 + bcnt[exp_fu[s]]));
                    end
                    bcnt[exp_fu[s]]++;
                end
                for (int i = 0; i < 3; i++) if (clear_valid_a[i]) gcnt[i]++;
            end
        end
        fu_valid_a = 3'b000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gcnt[i] !== 20) begin
                errors++; $display("FAIL fair_count fu%0d: got %0d grants, want 20", i, gcnt[i]);
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        fu_valid_a = 3'b111;
        fu_tag_a = {4'd10, 4'd9, 4'd8};
        fu_data_a = {16'hEEE2, 16'hEEE1, 16'hEEE0};
        fu_entry_a = 6'b10_01_00;
        repeat (4) tick();
        // Each queue now holds two entries; flush alongside a fresh FU1 push.
        fu_valid_a = 3'b010;
        fu_tag_a[7:4] = 4'd12;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        fu_valid_a = 3'b000;
        checks++;
        if (cdb_valid_a !== 2'b00 || clear_valid_a !== 3'b000 || fu_ready_a !== 3'b111) begin
            errors++; $display("FAIL flush_clear: got v=%b clr=%b rdy=%b, want 00/000/111", cdb_valid_a, clear_valid_a, fu_ready_a);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (cdb_valid_a !== 2'b00) begin
                errors++; $display("FAIL flush_stale c=%0d: got v=%b t=%h, want nothing", c, cdb_valid_a, cdb_tag_a);
            end
        end
        fu_valid_a = 3'b100;
        fu_tag_a[11:8] = 4'd3;
        fu_data_a[47:32] = 16'h5A5A;
        tick();
        fu_valid_a = 3'b000;
        tick();
        checks++;
        if (cdb_valid_a !== 2'b01 || cdb_tag_a[3:0] !== 4'd3 || cdb_data_a[15:0] !== 16'h5A5A) begin
            errors++; $display("FAIL flush_recover: got v=%b t=%h d=%h, want v=01 t=3 d=5a5a", cdb_valid_a, cdb_tag_a[3:0], cdb_data_a[15:0]);
        end
    endtask

    task automatic test_backpressure();
        int bcnt [3];
        int f;
        logic [2:0] acc;
        logic saw_stall;
        apply_reset();
        for (int i = 0; i < 3; i++) begin seq_b[i] = 0; bcnt[i] = 0; end
        saw_stall = 1'b0;
        fu_valid_b = 3'b111;
        drive_seq_b();
        for (int c = 0; c < 40; c++) begin
            if (c == 24) fu_valid_b = 3'b000;
            if (fu_ready_b !== 3'b111) saw_stall = 1'b1;
            acc = fu_valid_b & fu_ready_b;
            tick();
            for (int i = 0; i < 3; i++) if (acc[i]) seq_b[i]++;
            drive_seq_b();
            if (cdb_valid_b === 1'b1) begin
                f = int'(cdb_tag_b);
                checks++;
                if (f > 2 || bcnt[f] >= seq_b[f]) begin
                    errors++; $display("FAIL bp_spurious c=%0d: got tag %h", c, cdb_tag_b);
                end else begin
                    checks++;
                    if (cdb_data_b !== 16'(f * 4096 + bcnt[f]) || clear_valid_b !== 3'(1 << f)
                        || clear_entry_b[f*2 +: 2] !== 2'(bcnt[f])) begin
                        errors++; $display("FAIL bp_order c=%0d fu%0d: got d=%h clr=%b e=%b, want d=%h", c, f, cdb_data_b, clear_valid_b, clear_entry_b, 16'(f * 4096 + bcnt[f]));
                    end
                    bcnt[f]++;
                end
            end
        end
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++; $display("FAIL bp_ready_drop: got fu_ready never deasserted, want a stall");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bcnt[i] !== seq_b[i] || seq_b[i] == 0) begin
                errors++; $display("FAIL bp_exactly_once fu%0d: got %0d broadcast, want %0d accepted", i, bcnt[i], seq_b[i]);
            end
        end
    endtask

    initial begin
        flush_a = 1'b0; flush_b = 1'b0;
        fu_valid_a = '0; fu_valid_b = '0;
        fu_tag_a = '0; fu_data_a = '0; fu_entry_a = '0;
        fu_tag_b = '0; fu_data_b = '0; fu_entry_b = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_flush();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Collects completed results from `NUM_FU` functional units.
- Queues each unit's results in its own small FIFO.
- Each cycle, broadcasts up to `NUM_CDB` of them on the common data bus (CDB), with round-robin fairness.
- Sits between the execution units and the reservation stations/ROB, and replaces the fixed-priority execute buffer. Unlike that buffer, results are never lost when the CDB is oversubscribed: producers see backpressure.

## Interface

**Parameters**
- `NUM_FU`, default 3: number of functional-unit result sources.
- `NUM_CDB`, default 2: number of CDB broadcast slots per cycle. Must satisfy 1 ≤ `NUM_CDB` ≤ `NUM_FU`.
- `DATA_W`, default 16: result data width.
- `TAG_W`, default 4: ROB destination tag width.
- `ENTRY_W`, default 2: reservation-station entry index width.
- `FIFO_DEPTH`, default 2: per-FU queue depth. Must be a power of two, ≥ 2.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  mispredict flush; discards all queued and in-flight results.
- `fu_valid`  in  `NUM_FU`  result offered by FU i.
- `fu_ready`  out  `NUM_FU`  FU i queue can accept.
- `fu_tag`  in  `NUM_FU*TAG_W`  packed ROB tags; FU i occupies bits [i*TAG_W +: TAG_W].
- `fu_data`  in  `NUM_FU*DATA_W`  packed result data.
- `fu_entry`  in  `NUM_FU*ENTRY_W`  packed RS entry that issued the result.
- `cdb_valid`  out  `NUM_CDB`  slot k carries a result.
- `cdb_tag`  out  `NUM_CDB*TAG_W`  packed broadcast tags.
- `cdb_data`  out  `NUM_CDB*DATA_W`  packed broadcast data.
- `clear_valid`  out  `NUM_FU`  FU i's result broadcast this cycle; the RS frees its entry.
- `clear_entry`  out  `NUM_FU*ENTRY_W`  RS entry to free, per FU.

## Operation

**Enqueue**
- A push occurs on a rising edge when `fu_valid[i] && fu_ready[i] && !flush`.
- `fu_ready[i] = (count[i] != FIFO_DEPTH)`. It is derived from registered count only, with no pop-through.
- `fu_valid` while not ready is ignored, and the producer must hold the result.

**Arbitration**
- The arbitration is combinational over the non-empty FIFO heads.
- Scan FUs starting at `rr_ptr`, wrapping modulo `NUM_FU`.
- The first `NUM_CDB` non-empty FUs are granted, in scan order. The first grant goes to slot 0, the next to slot 1, and so on.
- Each FU gets at most one grant per cycle (head only).
- Granted FIFOs pop on the edge.
- If any grant occurred, `rr_ptr` becomes (last granted FU + 1) mod `NUM_FU`. Otherwise `rr_ptr` holds.

**Broadcast registers**
- On each edge, `cdb_*` load the granted heads.
- Unused slots load `valid`=0, with tag/data 0.
- `clear_valid[i]`=1 and `clear_entry[i]` = head entry for each granted FU. Otherwise 0 and 0.
- All outputs except `fu_ready` are registered.

**Simultaneous push and pop** on one FIFO in the same edge: count unchanged, order preserved.

**Flush**
- On the edge where `flush`=1: all FIFO counts/pointers cleared and all `cdb_*`/`clear_*` registers cleared.
- Any push in that cycle is dropped.
- `rr_ptr` is preserved.

**Reset**
- `rst` has priority over `flush`.
- Clears counts, pointers and `rr_ptr` to 0.
- Clears `cdb_valid`, `cdb_tag`, `cdb_data`, `clear_valid` and `clear_entry` to 0.
- `fu_ready` = all ones in the cycle after reset.

## Timing

- Minimum latency is 2 edges:
  - A push at edge E0 makes the result the FIFO head.
  - If it is granted, it appears on `cdb_*`/`clear_*` after edge E1, valid for exactly one cycle.
- Throughput: up to `NUM_CDB` results per cycle aggregate, at most 1 per FU.
- Starvation bound: a non-empty FIFO is granted within ceil(`NUM_FU`/`NUM_CDB`) cycles.
- Each accepted result is broadcast exactly once, in per-FU arrival order, unless flushed.
- `fu_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop.

## Structure

**Shared package `cdb_pkg`**
- Default `DATA_W`/`TAG_W`/`ENTRY_W` constants.
- Typedef `cdb_result_t` with fields {tag, data, entry}.

**Sub-module `result_fifo`**
- Parametrised by width and depth.
- Ports: push, pop, flush, head, count.
- Instantiated `NUM_FU` times.
- The round-robin grant logic stays in the top level.

## Test plan

- **Reset.** Assert `rst` 2 cycles with `fu_valid`=3'b111 → all `cdb_*`/`clear_*` 0, nothing enqueued, `fu_ready`=3'b111 after release.
- **Single result.** FU0 pushes tag 5, data 16'h1234, entry 2 → two edges later `cdb_valid`=2'b01, slot0 tag 5 data 16'h1234, `clear_valid`=3'b001, `clear_entry[0]`=2, for one cycle only.
- **Three-way contention.** FU0, FU1 and FU2 push together with `rr_ptr`=0 → cycle n: slot0 = FU0, slot1 = FU1; cycle n+1: slot0 = FU2, `cdb_valid`=2'b01; then `rr_ptr`=0.
- **Fairness.** All 3 FUs stream continuously (`FIFO_DEPTH`=4) → over 30 broadcast cycles each FU is granted exactly 20 times, in grant-pair sequence (0,1),(2,0),(1,2) repeating.
- **Backpressure.** `NUM_CDB`=1, all FUs push every cycle while ready → `fu_ready` bits drop, producers hold, and a scoreboard shows every accepted result broadcast exactly once, in order.
- **Flush.** Flush with each FIFO holding 2 entries plus a concurrent FU1 push → next cycle `cdb_valid`=0, `clear_valid`=0, `fu_ready`=3'b111, and no pre-flush tag ever appears afterwards.
